// File: rtl/dma_pkg.sv
// Shared types for the byte-stream DMA engine.
//   e_dma_direction : transfer direction (stream->memory or memory->stream)
//   e_dma_state     : state encoding of the DMA control FSM
package dma_pkg;

  typedef enum logic {
    DMA_WRITE = 1'b0,  // RX FIFO bytes are written to memory
    DMA_READ  = 1'b1   // memory words are streamed out to the TX FIFO
  } e_dma_direction;

  typedef enum logic [2:0] {
    IDLE,
    RX_BYTE,
    RX_WAIT,
    MEM_REQ,
    MEM_WAIT,
    TX_BYTE,
    ABORT_WAIT
  } e_dma_state;

  localparam int unsigned DMA_ADDR_W = 27;

endpackage

// File: rtl/mem_bus_if.sv
// Single-word memory bus between an initiator and the memory arbiter.
//   request : initiator holds high until the cycle ack is seen
//   ack     : one-cycle completion from the target; rdata valid only then
//   write   : 1 = write word, 0 = read word
//   wmask   : byte enables, [1] = bits 15:8 (even byte), [0] = bits 7:0
//   address : byte address of the 16-bit word (bit 0 always 0)
//   wdata   : write data, big-endian
//   rdata   : read data, big-endian
interface mem_bus_if;
  logic        request;
  logic        ack;
  logic        write;
  logic [1:0]  wmask;
  logic [31:0] address;
  logic [15:0] wdata;
  logic [15:0] rdata;

  modport controller (
    output request, write, wmask, address, wdata,
    input  ack, rdata
  );

  modport target (
    input  request, write, wmask, address, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/memory_dma.sv
// Byte-stream DMA engine: moves transfer_length bytes between an 8-bit FIFO
// pair and 16-bit big-endian memory, one word request at a time.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   start, stop        : one-cycle command pulses
//   direction          : 0 = RX stream -> memory, 1 = memory -> TX stream
//   starting_address   : first byte address
//   transfer_length    : byte count (0 gives a one-cycle busy pulse only)
//   busy               : transfer in progress
//   rx_empty/rx_read/rx_rdata : RX FIFO pop side (data valid cycle after pop)
//   tx_full/tx_write/tx_wdata : TX FIFO push side
//   mem_bus            : controller side of the memory bus
module memory_dma
  import dma_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        direction,
  input  logic [26:0] starting_address,
  input  logic [26:0] transfer_length,
  output logic        busy,
  input  logic        rx_empty,
  output logic        rx_read,
  input  logic [7:0]  rx_rdata,
  input  logic        tx_full,
  output logic        tx_write,
  output logic [7:0]  tx_wdata,
  mem_bus_if.controller mem_bus
);

  e_dma_state     state_reg, state_next;
  e_dma_direction dir_reg, dir_next;
  logic [26:0]    address_reg, address_next;
  logic [26:0]    remaining_reg, remaining_next;
  logic [15:0]    word_buf_reg, word_buf_next;
  logic [1:0]     mask_buf_reg, mask_buf_next;
  logic           busy_reg, busy_next;
  logic           request_reg, request_next;
  logic           bus_write_reg, bus_write_next;
  logic [1:0]     bus_wmask_reg, bus_wmask_next;
  logic [31:0]    bus_address_reg, bus_address_next;
  logic [15:0]    bus_wdata_reg, bus_wdata_next;
  logic           zero_start;
  logic [26:0]    word_address;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      dir_reg         <= DMA_WRITE;
      address_reg     <= '0;
      remaining_reg   <= '0;
      word_buf_reg    <= '0;
      mask_buf_reg    <= '0;
      busy_reg        <= 1'b0;
      request_reg     <= 1'b0;
      bus_write_reg   <= 1'b0;
      bus_wmask_reg   <= '0;
      bus_address_reg <= '0;
      bus_wdata_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      dir_reg         <= dir_next;
      address_reg     <= address_next;
      remaining_reg   <= remaining_next;
      word_buf_reg    <= word_buf_next;
      mask_buf_reg    <= mask_buf_next;
      busy_reg        <= busy_next;
      request_reg     <= request_next;
      bus_write_reg   <= bus_write_next;
      bus_wmask_reg   <= bus_wmask_next;
      bus_address_reg <= bus_address_next;
      bus_wdata_reg   <= bus_wdata_next;
    end
  end

  // On the write path address_reg has already moved past the last packed
  // byte, so the word being flushed is the one holding address_reg - 1.
  assign word_address = (dir_reg == DMA_WRITE) ? (address_reg - 27'd1) : address_reg;

  always_comb begin
    state_next       = state_reg;
    dir_next         = dir_reg;
    address_next     = address_reg;
    remaining_next   = remaining_reg;
    word_buf_next    = word_buf_reg;
    mask_buf_next    = mask_buf_reg;
    request_next     = request_reg;
    bus_write_next   = bus_write_reg;
    bus_wmask_next   = bus_wmask_reg;
    bus_address_next = bus_address_reg;
    bus_wdata_next   = bus_wdata_reg;
    rx_read          = 1'b0;
    tx_write         = 1'b0;
    tx_wdata         = 8'h00;
    zero_start       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start && !stop && !busy_reg) begin
          if (transfer_length == 27'd0) begin
            zero_start = 1'b1;
          end else begin
            dir_next       = e_dma_direction'(direction);
            address_next   = starting_address;
            remaining_next = transfer_length;
            word_buf_next  = '0;
            mask_buf_next  = '0;
            state_next     = direction ? MEM_REQ : RX_BYTE;
          end
        end
      end

      RX_BYTE: begin
        if (stop) begin
          state_next = IDLE;
        end else if (!rx_empty) begin
          rx_read    = 1'b1;
          state_next = RX_WAIT;
        end
      end

      RX_WAIT: begin
        if (stop) begin
          state_next = IDLE;
        end else begin
          if (address_reg[0]) begin
            word_buf_next[7:0] = rx_rdata;
            mask_buf_next[0]   = 1'b1;
          end else begin
            word_buf_next[15:8] = rx_rdata;
            mask_buf_next[1]    = 1'b1;
          end
          address_next   = address_reg + 27'd1;
          remaining_next = remaining_reg - 27'd1;
          // Flush after the odd lane or after the final byte.
          state_next = (address_reg[0] || remaining_reg == 27'd1) ? MEM_REQ : RX_BYTE;
        end
      end

      MEM_REQ: begin
        if (stop) begin
          state_next = IDLE;
        end else begin
          request_next     = 1'b1;
          bus_write_next   = (dir_reg == DMA_WRITE);
          bus_wmask_next   = (dir_reg == DMA_WRITE) ? mask_buf_reg : 2'b00;
          bus_wdata_next   = (dir_reg == DMA_WRITE) ? word_buf_reg : 16'h0000;
          bus_address_next = {5'b0, word_address & ~27'd1};
          state_next       = MEM_WAIT;
        end
      end

      MEM_WAIT: begin
        if (mem_bus.ack) begin
          request_next = 1'b0;
          if (dir_reg == DMA_WRITE) begin
            mask_buf_next = '0;
            word_buf_next = '0;
            state_next    = (stop || remaining_reg == 27'd0) ? IDLE : RX_BYTE;
          end else begin
            word_buf_next = mem_bus.rdata;
            state_next    = stop ? IDLE : TX_BYTE;
          end
        end else if (stop) begin
          state_next = ABORT_WAIT;
        end
      end

      TX_BYTE: begin
        if (stop) begin
          state_next = IDLE;
        end else if (!tx_full) begin
          tx_write       = 1'b1;
          tx_wdata       = address_reg[0] ? word_buf_reg[7:0] : word_buf_reg[15:8];
          address_next   = address_reg + 27'd1;
          remaining_next = remaining_reg - 27'd1;
          if (remaining_reg == 27'd1) begin
            state_next = IDLE;
          end else if (address_reg[0]) begin
            state_next = MEM_REQ;
          end
        end
      end

      ABORT_WAIT: begin
        // The bus cannot be abandoned mid-request; drain it and drop the data.
        if (mem_bus.ack) begin
          request_next = 1'b0;
          state_next   = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE) || zero_start;
  end

  assign busy            = busy_reg;
  assign mem_bus.request = request_reg;
  assign mem_bus.write   = bus_write_reg;
  assign mem_bus.wmask   = bus_wmask_reg;
  assign mem_bus.address = bus_address_reg;
  assign mem_bus.wdata   = bus_wdata_reg;

endmodule

// File: tb/tb_memory_dma.sv
// Directed bench for memory_dma with an RX FIFO model, a TX scoreboard and a
// memory responder with programmable ack latency.
module tb_memory_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        direction = 1'b0;
  logic [26:0] starting_address = '0;
  logic [26:0] transfer_length = '0;
  logic        busy;
  logic        rx_empty = 1'b1;
  logic        rx_read;
  logic [7:0]  rx_rdata = 8'h00;
  logic        tx_full = 1'b0;
  logic        tx_write;
  logic [7:0]  tx_wdata;

  mem_bus_if bus();

  memory_dma dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .stop             (stop),
    .direction        (direction),
    .starting_address (starting_address),
    .transfer_length  (transfer_length),
    .busy             (busy),
    .rx_empty         (rx_empty),
    .rx_read          (rx_read),
    .rx_rdata         (rx_rdata),
    .tx_full          (tx_full),
    .tx_write         (tx_write),
    .tx_wdata         (tx_wdata),
    .mem_bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [15:0] dmask;
    logic [1:0]  wmask;
  } bus_exp_t;

  bus_exp_t   exp_bus_q[$];
  logic [7:0] exp_tx_q[$];
  logic [7:0] rx_q[$];
  logic [15:0] rd_q[$];

  int errors = 0;
  int checks = 0;
  int tx_count = 0;
  int rx_reads = 0;
  int ack_count = 0;
  int req_count = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  logic rx_pop_pending = 1'b0;

  logic        prev_req = 1'b0;
  logic        prev_write = 1'b0;
  logic [1:0]  prev_wmask = '0;
  logic [31:0] prev_addr = '0;
  logic [15:0] prev_wdata = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitors, TX scoreboard and memory responder, all sampled on negedge.
  initial begin
    bus.ack = 1'b0;
    bus.rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (tx_write) begin
        tx_count++;
        check("tx_while_full", tx_full, 1'b0);
        check("tx_expected_pending", (exp_tx_q.size() != 0), 1'b1);
        if (exp_tx_q.size() != 0) check("tx_byte", tx_wdata, exp_tx_q.pop_front());
        $display("tx byte %02h", tx_wdata);
      end
      if (rx_read) begin
        rx_reads++;
        rx_pop_pending = 1'b1;
      end
      if (bus.request && !prev_req) req_count++;
      if (bus.request && prev_req) begin
        check("stable_addr", bus.address, prev_addr);
        check("stable_wdata", bus.wdata, prev_wdata);
        check("stable_ctrl", {bus.write, bus.wmask}, {prev_write, prev_wmask});
      end
      prev_req   = bus.request;
      prev_write = bus.write;
      prev_wmask = bus.wmask;
      prev_addr  = bus.address;
      prev_wdata = bus.wdata;

      if (bus.ack) begin
        bus.ack = 1'b0;
      end else if (bus.request && !reset) begin
        if (wait_cnt >= ack_delay) begin
          bus.ack = 1'b1;
          ack_count++;
          wait_cnt = 0;
          bus.rdata = (!bus.write && rd_q.size() != 0) ? rd_q.pop_front() : 16'h0000;
          $display("bus %s addr=%08h wdata=%04h wmask=%b rdata=%04h",
                   bus.write ? "write" : "read", bus.address, bus.wdata, bus.wmask, bus.rdata);
          check("bus_expected_pending", (exp_bus_q.size() != 0), 1'b1);
          if (exp_bus_q.size() != 0) begin
            bus_exp_t e;
            e = exp_bus_q.pop_front();
            check("bus_write", bus.write, e.write);
            check("bus_addr", bus.address, e.addr);
            check("bus_wdata", bus.wdata & e.dmask, e.wdata & e.dmask);
            if (e.write) check("bus_wmask", bus.wmask, e.wmask);
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // RX FIFO model: pop requested in one cycle, data presented the next.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rx_pop_pending) begin
        rx_pop_pending = 1'b0;
        if (rx_q.size() != 0) rx_rdata = rx_q.pop_front();
      end
      rx_empty = (rx_q.size() == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bus(input logic wr, input logic [31:0] addr, input logic [15:0] wdata,
                          input logic [15:0] dmask, input logic [1:0] wmask);
    bus_exp_t e;
    e.write = wr; e.addr = addr; e.wdata = wdata; e.dmask = dmask; e.wmask = wmask;
    exp_bus_q.push_back(e);
  endtask

  task automatic start_xfer(input logic dir, input logic [26:0] addr, input logic [26:0] len);
    direction = dir;
    starting_address = addr;
    transfer_length = len;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && busy; i++) step();
    check(tag, busy, 1'b0);
  endtask

  task automatic wait_req(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && !bus.request; i++) step();
    check(tag, bus.request, 1'b1);
  endtask

  int base_ack, base_tx, base_rx, base_req;

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (3) step();
    check("reset_busy", busy, 1'b0);
    check("reset_rx_read", rx_read, 1'b0);
    check("reset_tx", {tx_write, tx_wdata}, 9'h000);
    check("reset_req", {bus.request, bus.write, bus.wmask}, 4'h0);
    check("reset_addr", bus.address, 32'h0);
    check("reset_wdata", bus.wdata, 16'h0);
    reset = 1'b0;
    step();

    // Write 0x100, length 4
    rx_q.push_back(8'h11); rx_q.push_back(8'h22); rx_q.push_back(8'h33); rx_q.push_back(8'h44);
    push_bus(1'b1, 32'h100, 16'h1122, 16'hFFFF, 2'b11);
    push_bus(1'b1, 32'h102, 16'h3344, 16'hFFFF, 2'b11);
    base_ack = ack_count;
    start_xfer(1'b0, 27'h100, 27'd4);
    check("w1_busy_after_start", busy, 1'b1);
    wait_idle("w1_done", 200);
    check("w1_acks", ack_count - base_ack, 2);
    check("w1_bus_drained", exp_bus_q.size(), 0);
    $display("write 0x100 len 4 complete");

    // Write 0x101, length 2: odd start and odd end lanes
    rx_q.push_back(8'hAA); rx_q.push_back(8'hBB);
    push_bus(1'b1, 32'h100, 16'h00AA, 16'h00FF, 2'b01);
    push_bus(1'b1, 32'h102, 16'hBB00, 16'hFF00, 2'b10);
    base_ack = ack_count;
    start_xfer(1'b0, 27'h101, 27'd2);
    wait_idle("w2_done", 200);
    check("w2_acks", ack_count - base_ack, 2);
    $display("write 0x101 len 2 complete");

    // Read 0x200, length 3 with TX back-pressure
    ack_delay = 2;
    rd_q.push_back(16'hDEAD); rd_q.push_back(16'hBEEF);
    push_bus(1'b0, 32'h200, 16'h0, 16'h0, 2'b00);
    push_bus(1'b0, 32'h202, 16'h0, 16'h0, 2'b00);
    exp_tx_q.push_back(8'hDE); exp_tx_q.push_back(8'hAD); exp_tx_q.push_back(8'hBE);
    base_ack = ack_count;
    base_tx = tx_count;
    start_xfer(1'b1, 27'h200, 27'd3);
    for (int i = 0; i < 100 && tx_count == base_tx; i++) step();
    check("r1_first_tx", tx_count - base_tx, 1);
    tx_full = 1'b1;
    repeat (5) step();
    tx_full = 1'b0;
    wait_idle("r1_done", 200);
    check("r1_tx_count", tx_count - base_tx, 3);
    check("r1_bus_reads", ack_count - base_ack, 2);
    check("r1_tx_drained", exp_tx_q.size(), 0);
    $display("read 0x200 len 3 complete");

    // Zero length
    base_tx = tx_count; base_rx = rx_reads; base_req = req_count;
    start_xfer(1'b0, 27'h300, 27'd0);
    check("z_busy_pulse", busy, 1'b1);
    step();
    check("z_busy_fall", busy, 1'b0);
    repeat (3) step();
    check("z_no_req", req_count - base_req, 0);
    check("z_no_rx", rx_reads - base_rx, 0);
    check("z_no_tx", tx_count - base_tx, 0);
    $display("zero-length transfer complete");

    // Stop during MEM_WAIT of a read with ack delayed
    ack_delay = 10;
    rd_q.push_back(16'h1234);
    push_bus(1'b0, 32'h300, 16'h0, 16'h0, 2'b00);
    base_ack = ack_count; base_tx = tx_count;
    start_xfer(1'b1, 27'h300, 27'd2);
    wait_req("s_req_rise", 20);
    repeat (2) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (2) step();
    check("s_req_held", bus.request, 1'b1);
    check("s_busy_held", busy, 1'b1);
    wait_idle("s_done", 50);
    check("s_req_cleared", bus.request, 1'b0);
    check("s_one_ack", ack_count - base_ack, 1);
    repeat (3) step();
    check("s_no_tx", tx_count - base_tx, 0);
    $display("stop during read complete");

    // Reset with request outstanding, then a normal write
    base_ack = ack_count;
    start_xfer(1'b1, 27'h400, 27'd2);
    wait_req("rst_req_rise", 20);
    step();
    reset = 1'b1;
    step();
    check("rst_req_drop", bus.request, 1'b0);
    check("rst_busy_drop", busy, 1'b0);
    reset = 1'b0;
    step();
    check("rst_no_ack", ack_count - base_ack, 0);
    ack_delay = 1;
    rx_q.push_back(8'h5A); rx_q.push_back(8'hA5);
    push_bus(1'b1, 32'h010, 16'h5AA5, 16'hFFFF, 2'b11);
    base_ack = ack_count;
    start_xfer(1'b0, 27'h010, 27'd2);
    wait_idle("rst_w_done", 200);
    check("rst_w_acks", ack_count - base_ack, 1);
    check("rst_w_drained", exp_bus_q.size(), 0);
    $display("reset recovery write complete");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_dma.md
# memory_dma

Byte-stream DMA engine and bus initiator on the `mem_bus` controller side; the USB and SD data paths each instantiate one.
- Moves `transfer_length` bytes between an 8-bit FIFO pair and 16-bit big-endian memory starting at `starting_address`.
- Packs and unpacks bytes, derives `wmask` for odd start addresses and odd lengths, and issues one word request at a time.
- Its bus output feeds one input port of the memory arbiter.

## Interface
- No parameters.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle pulse; latches direction/address/length; ignored while `busy`.
- `stop`  in  1  one-cycle pulse; aborts the transfer.
- `direction`  in  1  0 = stream→memory (write), 1 = memory→stream (read).
- `starting_address`  in  27  byte address.
- `transfer_length`  in  27  byte count.
- `busy`  out  1  high from the cycle after an accepted `start` until done or aborted.
- `rx_empty`  in  1  RX FIFO empty.
- `rx_read`  out  1  RX pop pulse; `rx_rdata` is valid the following cycle.
- `rx_rdata`  in  8  RX byte.
- `tx_full`  in  1  TX FIFO full.
- `tx_write`  out  1  TX push pulse, qualified with `tx_wdata` in the same cycle.
- `tx_wdata`  out  8  TX byte.
- `mem_bus`  controller  modport fields: `request`, `ack`, `write`, `wmask[1:0]`, `address[31:0]`, `wdata[15:0]`, `rdata[15:0]`.

## Operation
- FSM states: IDLE, RX_BYTE, RX_WAIT, MEM_REQ, MEM_WAIT, TX_BYTE, and ABORT_WAIT.
- Registers:
  - `address` (27 bits), incremented by the number of bytes moved per word.
  - `remaining` (27 bits), decremented per byte.
  - `word_buf[15:0]`, `mask_buf[1:0]`, `dir`.
- Byte order: even address → `[15:8]` with `wmask[1]`; odd address → `[7:0]` with `wmask[0]`.
- Bus `address[31:0]` = `{5'b0, address[26:1], 1'b0}`.
- IDLE + `start`:
  - `transfer_length == 0` → `busy` pulses for one cycle and no bus or FIFO activity occurs.
  - Otherwise load the registers and go to RX_BYTE (write) or MEM_REQ (read).
- Write path:
  - RX_BYTE: when `!rx_empty`, pulse `rx_read` and go to RX_WAIT.
  - RX_WAIT: place `rx_rdata` in the lane selected by `address[0]`, set its mask bit, increment `address`, decrement `remaining`.
  - The word is complete when the odd lane was filled or `remaining` reaches 0 → MEM_REQ with `write = 1`; otherwise → RX_BYTE.
- Read path:
  - MEM_REQ with `write = 0`; on `ack` latch `rdata` → TX_BYTE.
  - TX_BYTE: while `!tx_full`, push the lane selected by `address[0]`, increment `address`, decrement `remaining`.
  - Stay in TX_BYTE for the odd lane unless `remaining` hits 0. After the odd lane → MEM_REQ, or IDLE when `remaining == 0`.
- MEM_REQ asserts `request` (registered); MEM_WAIT holds it until `ack`.
  - Write ack → clear `mask_buf`; go to IDLE if `remaining == 0`, else RX_BYTE.
- `stop`:
  - In any state without an outstanding request → IDLE next cycle.
  - With a request outstanding → ABORT_WAIT, which holds the request and goes to IDLE on `ack`. Read data is discarded; the FIFO is not pushed.
- A `start` that coincides with `stop`, or arrives while `busy`, is ignored.

## Timing
- Reset values: `busy` 0, `rx_read` 0, `tx_write` 0, `tx_wdata` 0; `mem_bus.request` 0, `write` 0, `wmask` 0, `address` 0, `wdata` 0; FSM in IDLE.
- A reset mid-transfer drops `request` immediately.
- Bus handshake:
  - `request` rises on the clock edge after MEM_REQ entry.
  - `write`, `wmask`, `address`, and `wdata` are stable while `request` is high.
  - `request` is cleared on the edge where `ack = 1`, and no new request is issued in that same cycle.
  - `rdata` is sampled only in the `ack` cycle.
- Bytes take 2 cycles each on RX and 1 cycle each on TX, plus bus latency per word.
- `busy` falls on the edge where the final `ack` or final `tx_write` completes.

## Structure
- Shared `dma_pkg`: `e_dma_direction` (`DMA_WRITE = 0`, `DMA_READ = 1`) and the FSM state enum.
- No sub-module; the FSM and the packer share counters, so the block is a single module.

## Test plan
- Write, address 0x100, length 4, RX bytes 11 22 33 44 → two writes:
  - 0x100 with `wdata` 0x1122, `wmask` 11.
  - 0x102 with `wdata` 0x3344, `wmask` 11.
  - `busy` falls after the 2nd `ack`.
- Write, address 0x101, length 2, bytes AA BB → two writes:
  - 0x100 with `wdata[7:0]` = 0xAA, `wmask` 01.
  - 0x102 with `wdata[15:8]` = 0xBB, `wmask` 10.
- Read, address 0x200, length 3, memory returns 0xDEAD then 0xBEEF → TX DE AD BE; exactly 2 bus reads; `tx_full` held 5 cycles mid-transfer → no byte lost or duplicated.
- Length 0 → `busy` pulses for 1 cycle; `request`, `rx_read`, and `tx_write` stay 0.
- `stop` during MEM_WAIT of a read with `ack` delayed 10 cycles → `request` held until `ack`, then IDLE, no `tx_write`.
- Reset asserted with `request` high → `request` 0 the next cycle; a following `start` runs correctly.
